// File: rtl/lsu_dmem_port.sv
// Load/store memory-access stage: drives a req/gnt/rvalid data-memory port, builds byte
// enables and replicated store data, and extends load data for writeback.
module lsu_dmem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_is_store_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        fault_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_store_q, is_store_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;
    logic             misalign_q, misalign_d;
    logic             fault_q, fault_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic [31:0]      dmem_addr_q, dmem_addr_d;
    logic [3:0]       dmem_be_q, dmem_be_d;
    logic [31:0]      dmem_wdata_q, dmem_wdata_d;

    logic        misaligned;
    logic        expire;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        misaligned = 1'b1;
        be_new     = 4'b1111;
        wdata_new  = req_wdata_i;
        unique case (req_size_i)
            2'b00: begin
                misaligned = 1'b0;
                be_new     = 4'b0001 << req_addr_i[1:0];
                wdata_new  = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr_i[0];
                be_new     = 4'b0011 << {req_addr_i[1], 1'b0};
                wdata_new  = {2{req_wdata_i[15:0]}};
            end
            2'b10: misaligned = |req_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Extraction uses the offset/size latched at accept; the live request may have moved on.
    always_comb begin
        lane = dmem_rdata_i >> {off_q, 3'b000};
        unique case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_store_d   = is_store_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        misalign_d   = 1'b0;
        fault_d      = 1'b0;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        stall_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && misaligned) begin
                    misalign_d = 1'b1;
                end else if (req_valid_i) begin
                    stall_o      = 1'b1;
                    state_d      = StReq;
                    cnt_d        = '0;
                    is_store_d   = req_is_store_i;
                    size_d       = req_size_i;
                    uns_d        = req_unsigned_i;
                    off_d        = req_addr_i[1:0];
                    wb_rd_d      = req_rd_i;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = req_is_store_i;
                    dmem_addr_d  = {req_addr_i[31:2], 2'b00};
                    dmem_be_d    = be_new;
                    dmem_wdata_d = wdata_new;
                end
            end
            StReq: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // rvalid is meaningless here, so expiry is unconditional and beats a late gnt.
                if (expire) begin
                    dmem_req_d = 1'b0;
                    fault_d    = 1'b1;
                    state_d    = StIdle;
                end else if (dmem_gnt_i) begin
                    dmem_req_d = 1'b0;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (dmem_rvalid_i) begin
                    state_d = StIdle;
                    if (dmem_err_i) begin
                        fault_d = 1'b1;
                    end else if (!is_store_q) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = load_ext;
                    end
                end else if (expire) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            is_store_q   <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            misalign_q   <= 1'b0;
            fault_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_store_q   <= is_store_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            misalign_q   <= misalign_d;
            fault_q      <= fault_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign misalign_o   = misalign_q;
    assign fault_o      = fault_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_be_o    = dmem_be_q;
    assign dmem_wdata_o = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: directed and random transactions against a transaction-level model.
module tb_lsu_dmem_port;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, misalign, fault, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_dmem_port #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_is_store_i(req_is_store),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_rd_i(req_rd), .stall_o(stall), .misalign_o(misalign),
        .fault_o(fault), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(gnt),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .dmem_err_i(err)
    );

    function automatic int m_nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (a % m_nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        nb = m_nbytes(sz);
        return 4'(((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] res;
        int nb;
        nb = m_nbytes(sz);
        for (int i = 0; i < 4; i++) res[8*i +: 8] = wd[8*(i % nb) +: 8];
        return res;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, mask;
        int nb;
        nb = m_nbytes(sz);
        v  = rd >> (8 * (a % 4));
        if (nb < 4) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            v    = v & mask;
            if (!uns && v[8*nb-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // g: REQ cycles before gnt (gnt never comes if g > TO-2); r: RESP cycles before rvalid.
    task automatic run_txn(input string nm, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [31:0] rdt, input logic e,
                           input int g, input int r);
        int   done;
        logic granted, completes, exp_stall, exp_req, exp_fault, exp_wb;
        req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_rd = rd; rdata = rdt; err = e;
        gnt = 1'b0; rvalid = 1'b0;
        #1;
        if (m_misaligned(sz, a)) begin
            n_tests++; if (stall !== 1'b0) begin n_fail++;
                $display("FAIL %s mis_stall got %b want 0", nm, stall); end
            @(posedge clk); #1;
            n_tests++; if (misalign !== 1'b1 || dmem_req !== 1'b0) begin n_fail++;
                $display("FAIL %s mis_pulse got mis=%b req=%b want 1,0", nm, misalign, dmem_req); end
            req_valid = 1'b0;
            @(posedge clk); #1;
            n_tests++; if (misalign !== 1'b0 || dmem_req !== 1'b0) begin n_fail++;
                $display("FAIL %s mis_end got mis=%b req=%b want 0,0", nm, misalign, dmem_req); end
            return;
        end
        n_tests++; if (stall !== 1'b1) begin n_fail++;
            $display("FAIL %s accept_stall got %b want 1", nm, stall); end
        granted   = (g <= int'(TO) - 2);
        completes = granted && (g + r + 1 <= int'(TO) - 1);
        done      = completes ? 2 + g + r : int'(TO);
        for (int c = 1; c <= done; c++) begin
            @(posedge clk); #1;
            exp_req = granted ? (c <= 1 + g) : 1'b1;
            n_tests++; if (dmem_req !== exp_req) begin n_fail++;
                $display("FAIL %s req_c%0d got %b want %b", nm, c, dmem_req, exp_req); end
            n_tests++; if ({fault, wb_valid, misalign} !== 3'b000) begin n_fail++;
                $display("FAIL %s early_pulse_c%0d got %b want 000", nm, c,
                         {fault, wb_valid, misalign}); end
            if (c == 1) begin
                n_tests++;
                if (dmem_we !== st || dmem_addr !== {a[31:2], 2'b00} || dmem_be !== m_be(sz, a)
                    || (st && dmem_wdata !== m_wdata(sz, wd))) begin
                    n_fail++;
                    $display("FAIL %s bus got we=%b a=%h be=%b wd=%h want %b %h %b %h", nm,
                             dmem_we, dmem_addr, dmem_be, dmem_wdata, st, {a[31:2], 2'b00},
                             m_be(sz, a), m_wdata(sz, wd));
                end
            end
            gnt    = granted && (c == 1 + g);
            rvalid = completes && (c == done);
            #1;
            exp_stall = (c < done) ? 1'b1 : (completes ? 1'b0 : !granted);
            n_tests++; if (stall !== exp_stall) begin n_fail++;
                $display("FAIL %s stall_c%0d got %b want %b", nm, c, stall, exp_stall); end
            if (!exp_stall) req_valid = 1'b0;
        end
        @(posedge clk); #1;
        gnt = 1'b0; rvalid = 1'b0;
        exp_fault = completes ? e : 1'b1;
        exp_wb    = completes && !e && !st;
        n_tests++; if (fault !== exp_fault || wb_valid !== exp_wb || dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL %s result got fault=%b wb=%b req=%b want %b %b 0", nm,
                               fault, wb_valid, dmem_req, exp_fault, exp_wb); end
        if (exp_wb) begin
            n_tests++;
            if (wb_rd !== rd || wb_data !== m_load(sz, uns, a, rdt)) begin n_fail++;
                $display("FAIL %s wb_data got rd=%0d d=%h want %0d %h", nm, wb_rd, wb_data, rd,
                         m_load(sz, uns, a, rdt)); end
        end
        req_valid = 1'b0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++;
            $display("FAIL %s idle_stall got %b want 0", nm, stall); end
        @(posedge clk); #1;
        n_tests++; if (fault !== 1'b0 || wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL %s pulse_width got fault=%b wb=%b want 0,0", nm, fault, wb_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({stall, misalign, fault, wb_valid, wb_rd, wb_data, dmem_req, dmem_we, dmem_addr,
             dmem_be, dmem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset outputs not all zero: req=%b be=%b wb=%b fault=%b",
                               dmem_req, dmem_be, wb_valid, fault);
        end
    endtask

    task automatic test_directed();
        run_txn("lb", 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd5, 32'h80123456, 1'b0, 1, 1);
        run_txn("lhu", 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 5'd9, 32'h80011234, 1'b0, 1, 1);
        run_txn("sb", 1'b1, 2'b00, 1'b0, 32'h3001, 32'h000000AB, 5'd3, 32'h0, 1'b0, 0, 0);
        run_txn("lw_mis", 1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 5'd1, 32'h0, 1'b0, 0, 0);
        run_txn("sz11", 1'b0, 2'b11, 1'b0, 32'h4000, 32'h0, 5'd1, 32'h0, 1'b0, 0, 0);
        run_txn("sh_err", 1'b1, 2'b01, 1'b0, 32'h7002, 32'h1234CAFE, 5'd2, 32'h0, 1'b1, 0, 1);
        run_txn("lh_edge", 1'b0, 2'b01, 1'b0, 32'h8000, 32'h0, 5'd31, 32'h1234F00D, 1'b0, 0, 2);
    endtask

    task automatic test_timeout();
        run_txn("to_nognt", 1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 5'd4, 32'h0, 1'b0, 3, 0);
        run_txn("to_resp", 1'b1, 2'b10, 1'b0, 32'h6004, 32'h55AA55AA, 5'd4, 32'h0, 1'b0, 0, 3);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h5000; req_rd = 5'd7; rdata = 32'hDEADBEEF; err = 1'b0;
        @(posedge clk); #1 gnt = 1'b1;
        @(posedge clk); #1 gnt = 1'b0; rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        n_tests++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid state got req=%b stall=%b want 0,0", dmem_req, stall); end
        rvalid = 1'b1;
        @(posedge clk); #1 rvalid = 1'b0;
        n_tests++; if (wb_valid !== 1'b0 || fault !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid late_rvalid got wb=%b fault=%b want 0,0", wb_valid, fault); end
        @(posedge clk); #1;
        n_tests++; if (wb_valid !== 1'b0 || fault !== 1'b0 || dmem_req !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid quiet got wb=%b fault=%b req=%b want 0", wb_valid, fault,
                     dmem_req); end
        run_txn("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 5'd7, 32'hCAFEF00D, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [1:0] sz;
        for (int i = 0; i < 80; i++) begin
            sz = 2'($urandom_range(0, 3));
            run_txn("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom,
                    $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
